// File: rtl/int_dscrptr_fetch_if.sv
// int_dscrptr_fetch_if: load request/ack, descriptor register-file read port and engine hand-off.
interface int_dscrptr_fetch_if #(
    parameter int NUM_INT_BDS_WIDTH = 2
);
    logic                         ldDscrptr;
    logic [NUM_INT_BDS_WIDTH-1:0] ldDscrptrNum;
    logic                         ldIntDscrptrAck;
    logic                         dscrptrRdEn;
    logic [NUM_INT_BDS_WIDTH+1:0] dscrptrRdAddr;
    logic [31:0]                  dscrptrRdData;
    logic                         dscrptrValid;
    logic                         dscrptrReady;
    logic [NUM_INT_BDS_WIDTH-1:0] dscrptrNum;
    logic [31:0]                  dscrptrCfg;
    logic [31:0]                  dscrptrByteCnt;
    logic [31:0]                  dscrptrSrcAddr;
    logic [31:0]                  dscrptrDstAddr;
    logic                         dscrptrInvalid;

    modport slave (
        input  ldDscrptr, ldDscrptrNum, dscrptrRdData, dscrptrReady,
        output ldIntDscrptrAck, dscrptrRdEn, dscrptrRdAddr, dscrptrValid, dscrptrNum,
               dscrptrCfg, dscrptrByteCnt, dscrptrSrcAddr, dscrptrDstAddr, dscrptrInvalid
    );

    modport master (
        output ldDscrptr, ldDscrptrNum, dscrptrRdData, dscrptrReady,
        input  ldIntDscrptrAck, dscrptrRdEn, dscrptrRdAddr, dscrptrValid, dscrptrNum,
               dscrptrCfg, dscrptrByteCnt, dscrptrSrcAddr, dscrptrDstAddr, dscrptrInvalid
    );
endinterface

// File: rtl/int_dscrptr_fetch.sv
// int_dscrptr_fetch: loads one internal buffer descriptor from the register file and hands it to the transfer engine.
module int_dscrptr_fetch #(
    parameter int NUM_INT_BDS       = 4,
    parameter int NUM_INT_BDS_WIDTH = 2
) (
    input logic                clock,
    input logic                reset,
    int_dscrptr_fetch_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FETCH, LAST, PRESENT, ACK, HOLDOFF} state_t;

    state_t                       state, state_nxt;
    logic [NUM_INT_BDS_WIDTH-1:0] num;
    logic [1:0]                   idx, wr_idx;
    logic                         rd_pend, inv, rd_en, out_of_range;
    logic [31:0]                  words [4];

    assign rd_en        = state == FETCH;
    assign out_of_range = 32'(bus.ldDscrptrNum) >= NUM_INT_BDS;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            num     <= '0;
            idx     <= '0;
            wr_idx  <= '0;
            rd_pend <= 1'b0;
            inv     <= 1'b0;
            words   <= '{default: '0};
        end else begin
            state   <= state_nxt;
            idx     <= rd_en ? idx + 2'd1 : 2'd0;
            rd_pend <= rd_en;
            wr_idx  <= idx;
            if (rd_pend) words[wr_idx] <= bus.dscrptrRdData;
            if (state == IDLE && bus.ldDscrptr) begin
                num <= bus.ldDscrptrNum;
                inv <= out_of_range;
            end
            if (state == LAST) inv <= ~words[0][0];
        end
    end

    // word 3 lands during LAST, so the cfg valid bit is already registered there
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.ldDscrptr) state_nxt = out_of_range ? ACK : FETCH;
            FETCH:   if (idx == 2'd3) state_nxt = LAST;
            LAST:    state_nxt = words[0][0] ? PRESENT : ACK;
            PRESENT: if (bus.dscrptrReady) state_nxt = ACK;
            ACK:     state_nxt = HOLDOFF;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.ldIntDscrptrAck = state == ACK;
    assign bus.dscrptrInvalid  = state == ACK && inv;
    assign bus.dscrptrRdEn     = rd_en;
    assign bus.dscrptrRdAddr   = rd_en ? {num, idx} : '0;
    assign bus.dscrptrValid    = state == PRESENT;
    assign bus.dscrptrNum      = num;
    assign bus.dscrptrCfg      = words[0];
    assign bus.dscrptrByteCnt  = words[1];
    assign bus.dscrptrSrcAddr  = words[2];
    assign bus.dscrptrDstAddr  = words[3];
endmodule

// File: tb/tb_int_dscrptr_fetch.sv
// tb_int_dscrptr_fetch: directed vector table plus hand-written corner sequences for int_dscrptr_fetch.
module tb_int_dscrptr_fetch;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int_dscrptr_fetch_if #(.NUM_INT_BDS_WIDTH(2)) bus ();
    int_dscrptr_fetch_if #(.NUM_INT_BDS_WIDTH(2)) bus3 ();

    int_dscrptr_fetch #(.NUM_INT_BDS(4), .NUM_INT_BDS_WIDTH(2)) dut (
        .clock(clock), .reset(reset), .bus(bus.slave));
    int_dscrptr_fetch #(.NUM_INT_BDS(3), .NUM_INT_BDS_WIDTH(2)) dut3 (
        .clock(clock), .reset(reset), .bus(bus3.slave));

    localparam logic [127:0] W0 = {32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0, 32'h0000_0001};
    localparam logic [127:0] W1 = {32'h0000_00B3, 32'h0000_00B2, 32'h0000_00B1, 32'h0000_0000};
    localparam logic [127:0] W2 = {32'h2000_0000, 32'h1000_0000, 32'h0000_0100, 32'h0000_0001};
    localparam logic [127:0] W3 = {32'h0033_3333, 32'h0000_3333, 32'h0000_0033, 32'h8000_0003};

    // register-file model: data one cycle after the read strobe, garbage otherwise
    logic [31:0] mem [16];
    always @(posedge clock) begin
        bus.dscrptrRdData  <= bus.dscrptrRdEn  ? mem[bus.dscrptrRdAddr]  : 32'hDEAD_BEEF;
        bus3.dscrptrRdData <= bus3.dscrptrRdEn ? mem[bus3.dscrptrRdAddr] : 32'hDEAD_BEEF;
    end

    typedef struct {
        logic         ld;
        logic [1:0]   num;
        logic         rdy;
        logic         rden;
        logic [3:0]   addr;
        logic         valid;
        logic         ack;
        logic         inv;
        logic         chk;
        logic [1:0]   e_num;
        logic [127:0] w;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   acks  = 0;
    int   invs  = 0;

    function automatic vec_t mk(input logic ld, input logic [1:0] num, input logic rdy,
                                input logic rden, input logic [3:0] addr, input logic valid,
                                input logic ack, input logic inv, input logic chk = 1'b0,
                                input logic [1:0] e_num = 2'd0, input logic [127:0] w = '0);
        vec_t v;
        v.ld = ld; v.num = num; v.rdy = rdy; v.rden = rden; v.addr = addr; v.valid = valid;
        v.ack = ack; v.inv = inv; v.chk = chk; v.e_num = e_num; v.w = w;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic outs(input string tag, input logic rden, input logic [3:0] addr,
                        input logic valid, input logic ack, input logic inv);
        cmp({tag, " rden"}, 32'(bus.dscrptrRdEn), 32'(rden));
        if (rden) cmp({tag, " addr"}, 32'(bus.dscrptrRdAddr), 32'(addr));
        cmp({tag, " valid"}, 32'(bus.dscrptrValid), 32'(valid));
        cmp({tag, " ack"}, 32'(bus.ldIntDscrptrAck), 32'(ack));
        cmp({tag, " inv"}, 32'(bus.dscrptrInvalid), 32'(inv));
    endtask

    task automatic words(input string tag, input logic [1:0] num, input logic [127:0] w);
        cmp({tag, " num"}, 32'(bus.dscrptrNum), 32'(num));
        cmp({tag, " cfg"}, bus.dscrptrCfg, w[31:0]);
        cmp({tag, " bytecnt"}, bus.dscrptrByteCnt, w[63:32]);
        cmp({tag, " src"}, bus.dscrptrSrcAddr, w[95:64]);
        cmp({tag, " dst"}, bus.dscrptrDstAddr, w[127:96]);
    endtask

    task automatic drive(input logic ld, input logic [1:0] num, input logic rdy);
        bus.ldDscrptr    = ld;
        bus.ldDscrptrNum = num;
        bus.dscrptrReady = rdy;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            mem[k]      = W0[k*32 +: 32];
            mem[4 + k]  = W1[k*32 +: 32];
            mem[8 + k]  = W2[k*32 +: 32];
            mem[12 + k] = W3[k*32 +: 32];
        end
        drive(1'b0, 2'd0, 1'b0);
        bus3.ldDscrptr    = 1'b0;
        bus3.ldDscrptrNum = 2'd0;
        bus3.dscrptrReady = 1'b0;

        // nominal num=2, ready already high at valid
        tbl.push_back(mk(1, 2, 0, 1, 8, 0, 0, 0));
        tbl.push_back(mk(1, 2, 0, 1, 9, 0, 0, 0));
        tbl.push_back(mk(1, 2, 0, 1, 10, 0, 0, 0));
        tbl.push_back(mk(1, 2, 0, 1, 11, 0, 0, 0));
        tbl.push_back(mk(1, 2, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 1, 0, 0, 1, 0, 0, 1, 2, W2));
        tbl.push_back(mk(1, 2, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, W2));
        // cfg[0]=0 for num=1: dropped, ack+invalid at T+6
        tbl.push_back(mk(1, 1, 0, 1, 4, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 5, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 6, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 7, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, W1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
        // back-to-back: ld held high, num 0 then 3; re-capture two cycles after ack
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 2, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 3, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0, 1, 0, W0));
        tbl.push_back(mk(1, 3, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 0, 1, 12, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 13, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 14, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 15, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0, 1, 3, W3));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));

        // reset state
        @(negedge clock);
        cyc();
        outs("reset", 0, 0, 0, 0, 0);
        words("reset", 2'd0, '0);
        cmp("reset dut3 ack", 32'(bus3.ldIntDscrptrAck), 32'd0);
        reset = 1'b0;
        cyc();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ld, tbl[i].num, tbl[i].rdy);
            cyc();
            outs($sformatf("row%0d", i), tbl[i].rden, tbl[i].addr, tbl[i].valid, tbl[i].ack, tbl[i].inv);
            if (tbl[i].chk) words($sformatf("row%0d", i), tbl[i].e_num, tbl[i].w);
            if (bus.ldIntDscrptrAck) acks++;
            if (bus.dscrptrInvalid) invs++;
        end
        cmp("table ack count", 32'(acks), 32'd4);
        cmp("table invalid count", 32'(invs), 32'd1);

        // ready held low 10 cycles after valid
        drive(1'b1, 2'd2, 1'b0);
        for (int i = 0; i < 6; i++) cyc();
        for (int i = 0; i < 10; i++) begin
            outs($sformatf("stall%0d", i), 0, 0, 1, 0, 0);
            words($sformatf("stall%0d", i), 2'd2, W2);
            cyc();
        end
        outs("stall end", 0, 0, 1, 0, 0);
        bus.dscrptrReady = 1'b1;
        cyc();
        outs("stall ack", 0, 0, 0, 1, 0);
        drive(1'b0, 2'd0, 1'b0);
        cyc();
        outs("stall holdoff", 0, 0, 0, 0, 0);
        cyc();

        // reset during FETCH idx 2 aborts with no ack
        drive(1'b1, 2'd3, 1'b0);
        cyc();
        cyc();
        cyc();
        outs("pre-abort", 1, 14, 0, 0, 0);
        reset = 1'b1;
        cyc();
        outs("abort", 0, 0, 0, 0, 0);
        words("abort", 2'd0, '0);
        reset = 1'b0;
        drive(1'b0, 2'd0, 1'b0);
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (bus.ldIntDscrptrAck || bus.dscrptrRdEn) acks++;
        end
        cmp("abort no activity", 32'(acks), 32'd0);
        drive(1'b1, 2'd0, 1'b1);
        for (int i = 0; i < 6; i++) cyc();
        outs("post-abort valid", 0, 0, 1, 0, 0);
        words("post-abort", 2'd0, W0);
        cyc();
        outs("post-abort ack", 0, 0, 0, 1, 0);
        drive(1'b0, 2'd0, 1'b0);
        cyc();

        // out-of-range num on a 3-descriptor instance: immediate ack+invalid, no reads
        bus3.ldDscrptr    = 1'b1;
        bus3.ldDscrptrNum = 2'd3;
        cyc();
        cmp("oor ack", 32'(bus3.ldIntDscrptrAck), 32'd1);
        cmp("oor inv", 32'(bus3.dscrptrInvalid), 32'd1);
        cmp("oor rden", 32'(bus3.dscrptrRdEn), 32'd0);
        cmp("oor valid", 32'(bus3.dscrptrValid), 32'd0);
        bus3.ldDscrptr = 1'b0;
        cyc();
        cmp("oor ack drop", 32'(bus3.ldIntDscrptrAck), 32'd0);
        cmp("oor inv drop", 32'(bus3.dscrptrInvalid), 32'd0);
        cmp("oor holdoff rden", 32'(bus3.dscrptrRdEn), 32'd0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
